// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package cla_pkg;
    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_SUB    = 1'b1;
    localparam int   MAX_GROUP = 8;

    // Subtract is A + ~B + ~cin, so the carry-in flips with the op bit.
    function automatic logic eff_cin(input logic cin, input logic op);
        return cin ^ (op == OP_SUB);
    endfunction
endpackage

// File: rtl/cla_group.sv
// One combinational lookahead group: every carry is a flat sum of products of g/p/c_in.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 8
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] s,
    output logic             c_out,
    output logic             c_msb,
    output logic             pg,
    output logic             gg
);
    logic [GROUP-1:0] p, g;
    logic [GROUP:0]   c;
    logic             gen_t, prop_t, gg_t;

    assign p = a ^ b;
    assign g = a & b;

    // gen_t accumulates g[j]&p[i..j+1]; no carry term ever depends on another c[].
    always_comb begin
        c      = '0;
        c[0]   = c_in;
        gen_t  = 1'b0;
        prop_t = 1'b0;
        gg_t   = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            gen_t  = g[i];
            prop_t = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                gen_t  = gen_t | (g[j] & prop_t);
                prop_t = prop_t & p[j];
            end
            c[i+1] = gen_t | (c_in & prop_t);
            gg_t   = gen_t;
        end
    end

    assign s     = p ^ c[GROUP-1:0];
    assign c_out = c[GROUP];
    assign c_msb = c[GROUP-1];
    assign pg    = &p;
    assign gg    = gg_t;
endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined add/sub: one lookahead group resolved per stage, valid/ready with full backpressure.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NG = WIDTH / GROUP;

    generate
        if (GROUP < 1 || GROUP > MAX_GROUP || (WIDTH % GROUP) != 0) begin : g_bad_param
            $error("cla_pipe_adder: GROUP must be 1..8 and divide WIDTH");
        end
    endgenerate

    logic                       advance;
    logic [WIDTH-1:0]           b_eff;
    logic                       c_eff;

    logic [NG-1:0]              vld_q, op_q, cy_q;
    logic [NG-1:0][WIDTH-1:0]   sum_q, a_q, b_q;
    logic                       ovf_q, zero_q;

    logic [NG-1:0]              vld_d, op_d;
    logic [NG-1:0][WIDTH-1:0]   sum_d, a_d, b_d;

    logic [NG-1:0][GROUP-1:0]   ga, gb, gs;
    logic [NG-1:0]              gc, gco, gcm, gpg, ggg;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;
    assign b_eff    = b ^ {WIDTH{op == OP_SUB}};
    assign c_eff    = eff_cin(cin, op);

    genvar k;
    generate
        for (k = 0; k < NG; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign vld_d[k] = in_valid;
                assign op_d[k]  = op;
                assign a_d[k]   = a;
                assign b_d[k]   = b_eff;
                assign gc[k]    = c_eff;
                assign sum_d[k] = WIDTH'(gs[k]);
            end else begin : g_next
                assign vld_d[k] = vld_q[k-1];
                assign op_d[k]  = op_q[k-1];
                assign a_d[k]   = a_q[k-1];
                assign b_d[k]   = b_q[k-1];
                assign gc[k]    = cy_q[k-1];
                // Upper bits of the previous partial sum are still zero, so OR-in is enough.
                assign sum_d[k] = sum_q[k-1] | (WIDTH'(gs[k]) << (k * GROUP));
            end
            assign ga[k] = a_d[k][k*GROUP +: GROUP];
            assign gb[k] = b_d[k][k*GROUP +: GROUP];

            cla_group #(.GROUP(GROUP)) u_grp (
                .a    (ga[k]),
                .b    (gb[k]),
                .c_in (gc[k]),
                .s    (gs[k]),
                .c_out(gco[k]),
                .c_msb(gcm[k]),
                .pg   (gpg[k]),
                .gg   (ggg[k])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= '0;
            op_q   <= '0;
            cy_q   <= '0;
            sum_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            vld_q  <= vld_d;
            op_q   <= op_d;
            cy_q   <= gco;
            sum_q  <= sum_d;
            a_q    <= a_d;
            b_q    <= b_d;
            ovf_q  <= gcm[NG-1] ^ gco[NG-1];
            zero_q <= ~|sum_d[NG-1];
        end
    end

    assign out_valid = vld_q[NG-1];
    assign sum       = sum_q[NG-1];
    assign cout      = cy_q[NG-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;
endmodule
